// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use interlock for an in-order pipeline.
// A tag shift register mirrors the instructions in EX..EX+D-1. The registered
// operand selects and the stall request are derived from it for the instruction in ID.
module fwd_hazard_unit #(
  parameter  int REG_AW    = 5,
  parameter  int FWD_DEPTH = 2,
  parameter  int STALL_CW  = 16,
  localparam int SELW      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                pipe_hold,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_rs1_use,
  input  logic                id_rs2_use,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_regwrite,
  input  logic [SELW-1:0]     id_rdy,
  output logic [SELW-1:0]     fwd_a,
  output logic [SELW-1:0]     fwd_b,
  output logic                stall,
  output logic [STALL_CW-1:0] stall_cnt
);

  // Tag entry k describes the instruction k stages after EX (k = 0 is EX itself).
  logic              tag_vld [FWD_DEPTH];
  logic [REG_AW-1:0] tag_rd  [FWD_DEPTH];
  logic [SELW-1:0]   tag_rdy [FWD_DEPTH];

  logic            en_a, en_b;
  logic [SELW-1:0] sel_a, sel_b;
  logic            haz_a, haz_b;
  logic            issue;

  // A ready stage of 0 means "ready right after EX"; beyond D it is clamped to the last stage.
  function automatic logic [SELW-1:0] norm_rdy(input logic [SELW-1:0] r);
    if (r == '0)
      return SELW'(1);
    else if (int'(r) > FWD_DEPTH)
      return SELW'(FWD_DEPTH);
    else
      return r;
  endfunction

  // The stall counter sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] c);
    if (&c)
      return c;
    else
      return c + STALL_CW'(1);
  endfunction

  assign en_a = id_valid & id_rs1_use & (id_rs1 != '0);
  assign en_b = id_valid & id_rs2_use & (id_rs2 != '0);

  // Youngest-producer lookup: the first match decides, so older entries with the same rd are shadowed.
  always_comb begin : lookup
    logic hit_a, hit_b;
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (en_a && !hit_a && tag_vld[k] && (tag_rd[k] == id_rs1)) begin
        hit_a = 1'b1;
        if (k + 1 >= int'(tag_rdy[k])) sel_a = SELW'(k + 1);
        else                           haz_a = 1'b1;
      end
      if (en_b && !hit_b && tag_vld[k] && (tag_rd[k] == id_rs2)) begin
        hit_b = 1'b1;
        if (k + 1 >= int'(tag_rdy[k])) sel_b = SELW'(k + 1);
        else                           haz_b = 1'b1;
      end
    end
  end

  // A redirect or a global freeze never needs the interlock.
  assign stall = (haz_a | haz_b) & ~flush & ~pipe_hold;
  assign issue = id_valid & ~stall & ~flush;

  // Control state: entry valids, registered selects and the stall counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < FWD_DEPTH; k++) tag_vld[k] <= 1'b0;
      fwd_a     <= '0;
      fwd_b     <= '0;
      stall_cnt <= '0;
    end else if (!pipe_hold) begin
      tag_vld[0] <= issue & id_regwrite & (id_rd != '0);
      for (int k = 1; k < FWD_DEPTH; k++) tag_vld[k] <= tag_vld[k-1];
      fwd_a <= issue ? sel_a : '0;
      fwd_b <= issue ? sel_b : '0;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Tag payload shifts with the valids; it is meaningless whenever the valid bit is clear.
  always_ff @(posedge clk) begin
    if (!pipe_hold) begin
      tag_rd[0]  <= id_rd;
      tag_rdy[0] <= norm_rdy(id_rdy);
      for (int k = 1; k < FWD_DEPTH; k++) begin
        tag_rd[k]  <= tag_rd[k-1];
        tag_rdy[k] <= tag_rdy[k-1];
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (D=2, 2-bit stall counter).
// Expected EX selects are queued when an instruction is presented in ID and checked one edge later.
module tb_fwd_hazard_unit;

  localparam int AW = 5;
  localparam int SW = 2;
  localparam int CW = 2;

  logic          clk, rstn, pipe_hold, flush, id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_rs1_use, id_rs2_use, id_regwrite;
  logic [SW-1:0] id_rdy, fwd_a, fwd_b;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string         tag;
    logic [SW-1:0] fa;
    logic [SW-1:0] fb;
  } exp_t;
  exp_t sb[$];

  fwd_hazard_unit #(.REG_AW(AW), .FWD_DEPTH(2), .STALL_CW(CW)) dut (
    .clk(clk), .rstn(rstn), .pipe_hold(pipe_hold), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_rdy(id_rdy), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Present one ID-stage input set, check stall, queue the expected EX selects, clock, check them.
  task automatic step(input string tag, input logic v,
                      input logic [AW-1:0] rs1, input logic u1,
                      input logic [AW-1:0] rs2, input logic u2,
                      input logic [AW-1:0] rd, input logic rw, input logic [SW-1:0] rdy,
                      input logic fl, input logic hd,
                      input logic es, input logic [SW-1:0] efa, input logic [SW-1:0] efb);
    exp_t e;
    id_valid = v;  id_rs1 = rs1; id_rs1_use = u1; id_rs2 = rs2; id_rs2_use = u2;
    id_rd = rd;    id_regwrite = rw; id_rdy = rdy; flush = fl; pipe_hold = hd;
    #1;
    chk({tag, ".stall"}, stall, es);
    sb.push_back('{tag, efa, efb});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".fwd_a"}, fwd_a, e.fa);
    chk({e.tag, ".fwd_b"}, fwd_b, e.fb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_pulse();
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; pipe_hold = 0; flush = 0; id_valid = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
    id_rd = 0; id_regwrite = 0; id_rdy = 0;
    #12;
    chk("reset.stall", stall, 0);
    chk("reset.fwd_a", fwd_a, 0);
    chk("reset.fwd_b", fwd_b, 0);
    chk("reset.cnt", stall_cnt, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    //           tag        v rs1 u1 rs2 u2 rd rw rdy fl hd  st fa fb
    // ALU chain
    step("alu.i1",   1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    step("alu.i2",   1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    idle(2);
    // Load-use: one stall cycle, then forward from EX+2
    step("ld.i1",    1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0, 0, 0);
    step("ld.i2",    1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    step("ld.i2r",   1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 2);
    chk("ld.cnt", stall_cnt, 1);
    idle(2);
    // Youngest producer wins
    step("yw.i1",    1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
    step("yw.i2",    1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
    step("yw.i3",    1, 3, 1, 3, 1, 0, 0, 1, 0, 0, 0, 1, 1);
    idle(2);
    // A ready older producer does not hide a not-ready younger one
    step("old.i1",   1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0);
    step("old.i2",   1, 0, 0, 0, 0, 4, 1, 2, 0, 0, 0, 0, 0);
    step("old.i3",   1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    step("old.i3r",  1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0);
    chk("old.cnt", stall_cnt, 2);
    idle(2);
    // x0 never forwarded, unused operand ignored
    step("x0.i1",    1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step("x0.i2",    1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    step("nouse.i1", 1, 0, 0, 0, 0, 9, 1, 2, 0, 0, 0, 0, 0);
    step("nouse.i2", 1, 9, 0, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    // id_rdy=0 acts as 1, id_rdy=3 acts as 2
    step("rdy0.i1",  1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0);
    step("rdy0.i2",  1, 10, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    step("rdy3.i1",  1, 0, 0, 0, 0, 11, 1, 3, 0, 0, 0, 0, 0);
    step("rdy3.i2",  1, 11, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    step("rdy3.i2r", 1, 11, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0);
    chk("rdy3.cnt", stall_cnt, 3);
    idle(2);

    // Flush during a load-use hazard
    rst_pulse();
    chk("rst2.cnt", stall_cnt, 0);
    step("fl.i1",    1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0, 0, 0);
    step("fl.i2",    1, 0, 0, 7, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("fl.cnt", stall_cnt, 0);
    // Freeze for 3 cycles with a pending hazard in ID
    step("hd.i1",    1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    step("hd.i2",    1, 5, 1, 0, 0, 6, 1, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step("hd.frz", 1, 6, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
    chk("hd.cnt", stall_cnt, 0);
    step("hd.i3",    1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    step("hd.i3r",   1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0);
    chk("hd.cnt2", stall_cnt, 1);
    idle(2);

    // Saturation: five load-use stalls on a 2-bit counter
    rst_pulse();
    for (int i = 0; i < 5; i++) begin
      step("sat.ld",  1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0, 0, 0);
      step("sat.use", 1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 1, 0, 0);
      step("sat.go",  1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 2);
      chk($sformatf("sat.cnt%0d", i), stall_cnt, (i + 1 > 3) ? 3 : i + 1);
    end

    // Asynchronous reset in the middle of a stall
    step("ar.i0",    1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0);
    step("ar.i1",    1, 12, 1, 0, 0, 7, 1, 2, 0, 0, 0, 1, 0);
    id_valid = 1; id_rs1 = 0; id_rs1_use = 0; id_rs2 = 7; id_rs2_use = 1;
    id_rd = 0; id_regwrite = 0; id_rdy = 1; flush = 0; pipe_hold = 0;
    #1;
    chk("ar.pre.stall", stall, 1);
    chk("ar.pre.fwd_a", fwd_a, 1);
    rstn = 1'b0;
    #1;
    chk("ar.stall", stall, 0);
    chk("ar.fwd_a", fwd_a, 0);
    chk("ar.fwd_b", fwd_b, 0);
    chk("ar.cnt", stall_cnt, 0);
    rstn = 1'b1;
    step("ar.i2",    1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("ar.cnt2", stall_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
